// File: rtl/riscv_id_if.sv
// -----------------------------------------------------------------------------
// riscv_id_pkg / riscv_id_if
//
// Package: ALU function codes shared by the decode stage and the execute stage.
//
// Interface: bundles the three buses around the decode stage.
//   if_id_*  : fetch -> decode instruction handshake (rdy/ack)
//   id_ex_*  : decode -> execute operand handshake (rdy/ack) plus dest tag
//   wb_*     : writeback port into the register file / scoreboard
//   id_illegal : one-cycle pulse after an undecodable instruction is consumed
// Modports:
//   slave  : the decode stage (riscv_id)
//   master : the environment driving fetch/execute/writeback
// -----------------------------------------------------------------------------
package riscv_id_pkg;

  localparam int EX_FUNCT_W = 4;

  typedef enum logic [EX_FUNCT_W-1:0] {
    EX_ADD  = 4'd0,
    EX_SUB  = 4'd1,
    EX_SLL  = 4'd2,
    EX_STL  = 4'd3,
    EX_STLU = 4'd4,
    EX_XOR  = 4'd5,
    EX_SRL  = 4'd6,
    EX_SRA  = 4'd7,
    EX_OR   = 4'd8,
    EX_AND  = 4'd9
  } ex_funct_e;

endpackage

interface riscv_id_if;
  import riscv_id_pkg::*;

  logic        if_id_rdy;
  logic        if_id_ack;
  logic [31:0] if_id_instr;

  logic        id_ex_rdy;
  logic        id_ex_ack;
  logic [31:0] id_ex_op1;
  logic [31:0] id_ex_op2;
  ex_funct_e   id_ex_funct;
  logic [4:0]  id_ex_rd;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_illegal;

  modport slave (
    input  if_id_rdy, if_id_instr, id_ex_ack, wb_we, wb_rd, wb_data,
    output if_id_ack, id_ex_rdy, id_ex_op1, id_ex_op2, id_ex_funct, id_ex_rd,
           id_illegal
  );

  modport master (
    output if_id_rdy, if_id_instr, id_ex_ack, wb_we, wb_rd, wb_data,
    input  if_id_ack, id_ex_rdy, id_ex_op1, id_ex_op2, id_ex_funct, id_ex_rd,
           id_illegal
  );

endinterface

// File: rtl/riscv_id.sv
// -----------------------------------------------------------------------------
// riscv_id : RV32I instruction decode stage (OP, OP-IMM, LUI).
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : riscv_id_if.slave
//          if_id  rdy/ack/instr      instruction in (ack is combinational)
//          id_ex  rdy/ack/op1/op2/funct/rd  operands out (registered)
//          wb     we/rd/data         register-file writeback
//          id_illegal                pulse the cycle after an illegal accept
//
// Operands come from an internal 32x32 register file with writeback bypass.
// A busy bit per register stalls instructions that read or overwrite a
// register whose result is still outstanding in the pipeline.
// -----------------------------------------------------------------------------
module riscv_id
  import riscv_id_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  riscv_id_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    OP2_REG,    // R[rs2]
    OP2_IMM,    // sign-extended I-immediate
    OP2_SHAMT,  // zero-extended 5-bit shift amount
    OP2_UIMM    // U-immediate
  } op2_sel_e;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign instr  = bus.if_id_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  assign wb_we   = bus.wb_we;
  assign wb_rd   = bus.wb_rd;
  assign wb_data = bus.wb_data;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] rf_q [32];
  logic [31:0] busy_q,   busy_d;
  logic        rdy_q,    rdy_d;
  logic [31:0] op1_q,    op1_d;
  logic [31:0] op2_q,    op2_d;
  ex_funct_e   funct_q,  funct_d;
  logic [4:0]  rd_q,     rd_d;
  logic        illegal_q, illegal_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic      dec_legal;
  ex_funct_e dec_funct;
  op2_sel_e  dec_op2_sel;
  logic      dec_op1_zero;
  logic      use_rs1;
  logic      use_rs2;
  logic      use_rd;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_legal    = 1'b0;
    dec_funct    = EX_ADD;
    dec_op2_sel  = OP2_REG;
    dec_op1_zero = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == F7_ZERO) begin
          dec_legal = 1'b1;
          unique case (funct3)
            3'b000: dec_funct = EX_ADD;
            3'b001: dec_funct = EX_SLL;
            3'b010: dec_funct = EX_STL;
            3'b011: dec_funct = EX_STLU;
            3'b100: dec_funct = EX_XOR;
            3'b101: dec_funct = EX_SRL;
            3'b110: dec_funct = EX_OR;
            3'b111: dec_funct = EX_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          // Only ADD and SRL have an alternate (SUB/SRA) form.
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_funct = EX_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_funct = EX_SRA;
          end
        end
      end

      OPC_OP_IMM: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        dec_op2_sel = OP2_IMM;
        unique case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_funct = EX_ADD;  end
          3'b010: begin dec_legal = 1'b1; dec_funct = EX_STL;  end
          3'b011: begin dec_legal = 1'b1; dec_funct = EX_STLU; end
          3'b100: begin dec_legal = 1'b1; dec_funct = EX_XOR;  end
          3'b110: begin dec_legal = 1'b1; dec_funct = EX_OR;   end
          3'b111: begin dec_legal = 1'b1; dec_funct = EX_AND;  end
          3'b001: begin
            dec_op2_sel = OP2_SHAMT;
            dec_funct   = EX_SLL;
            dec_legal   = (funct7 == F7_ZERO);
          end
          3'b101: begin
            dec_op2_sel = OP2_SHAMT;
            dec_funct   = (funct7 == F7_ALT) ? EX_SRA : EX_SRL;
            dec_legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          end
        endcase
      end

      OPC_LUI: begin
        use_rd       = 1'b1;
        dec_legal    = 1'b1;
        dec_funct    = EX_ADD;
        dec_op1_zero = 1'b1;
        dec_op2_sel  = OP2_UIMM;
      end

      default: ;
    endcase

    // An illegal instruction is consumed without touching the scoreboard, so
    // none of its register fields may cause a stall.
    if (!dec_legal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file read with same-cycle writeback bypass
  // ---------------------------------------------------------------------------
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  assign rs1_data = (rs1 == 5'd0)                ? 32'd0   :
                    (wb_we && (wb_rd == rs1))    ? wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0)                ? 32'd0   :
                    (wb_we && (wb_rd == rs2))    ? wb_data : rf_q[rs2];

  // ---------------------------------------------------------------------------
  // Hazard / handshake
  // ---------------------------------------------------------------------------
  // A writeback landing this cycle releases the register immediately.
  function automatic logic reg_busy(input logic [4:0] r);
    return (r != 5'd0) && busy_q[r] && !(wb_we && (wb_rd == r));
  endfunction

  logic free;
  logic hazard;
  logic accept;
  logic issue;

  assign free   = !rdy_q || bus.id_ex_ack;
  assign hazard = (use_rs1 && reg_busy(rs1)) ||
                  (use_rs2 && reg_busy(rs2)) ||
                  (use_rd  && reg_busy(rd));
  assign bus.if_id_ack = free && !hazard;
  assign accept = bus.if_id_rdy && bus.if_id_ack;
  assign issue  = accept && dec_legal;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy_d     = rdy_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    funct_d   = funct_q;
    rd_d      = rd_q;
    illegal_d = accept && !dec_legal;

    if (free) begin
      rdy_d = issue;
      if (issue) begin
        op1_d   = dec_op1_zero ? 32'd0 : rs1_data;
        funct_d = dec_funct;
        rd_d    = rd;
        unique case (dec_op2_sel)
          OP2_REG:   op2_d = rs2_data;
          OP2_IMM:   op2_d = {{20{instr[31]}}, instr[31:20]};
          OP2_SHAMT: op2_d = {27'd0, instr[24:20]};
          OP2_UIMM:  op2_d = {instr[31:12], 12'd0};
        endcase
      end
    end
  end

  // Clear first, then set, so an issue and a writeback to the same register
  // in one cycle leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_we) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue && (rd != 5'd0)) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order or block scheduling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      funct_q   <= EX_ADD;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      rdy_q     <= rdy_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      funct_q   <= funct_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the register file is built from flops and is cleared by reset so a
  // read after reset is deterministic; a RAM macro could not be reset this way.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign bus.id_ex_rdy   = rdy_q;
  assign bus.id_ex_op1   = op1_q;
  assign bus.id_ex_op2   = op2_q;
  assign bus.id_ex_funct = funct_q;
  assign bus.id_ex_rd    = rd_q;
  assign bus.id_illegal  = illegal_q;

endmodule

// File: tb/tb_riscv_id.sv
// -----------------------------------------------------------------------------
// tb_riscv_id : directed self-checking bench for riscv_id.
// Inputs are driven on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, combinational ack 1 time unit after driving.
// -----------------------------------------------------------------------------
module tb_riscv_id;
  import riscv_id_pkg::*;

  localparam logic [31:0] I_ADDI_X1_5     = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2_X1_X1  = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_LUI_X3        = 32'hABCD_E1B7; // lui  x3,0xABCDE
  localparam logic [31:0] I_XORI_X8_M1    = 32'hFFF0_4413; // xori x8,x0,-1
  localparam logic [31:0] I_MUL_X9        = 32'h0200_04B3; // funct7=0000001
  localparam logic [31:0] I_SRAI_BAD      = 32'h0230_D213; // imm[11:5]=0000001
  localparam logic [31:0] I_ADD_X6_X4_X0  = 32'h0002_0333; // add  x6,x4,x0
  localparam logic [31:0] I_SRAI_X4_X1_3  = 32'h4030_D213; // srai x4,x1,3
  localparam logic [31:0] I_ADD_X5_X0_X0  = 32'h0000_02B3; // add  x5,x0,x0
  localparam logic [31:0] I_ADD_X7_X5_X5  = 32'h0052_83B3; // add  x7,x5,x5

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  riscv_id_if bus ();

  riscv_id dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] op1,
                           input logic [31:0] op2, input ex_funct_e funct,
                           input logic [4:0] rd);
    check({tag, "_rdy"},   32'(bus.id_ex_rdy),   32'd1);
    check({tag, "_op1"},   bus.id_ex_op1,        op1);
    check({tag, "_op2"},   bus.id_ex_op2,        op2);
    check({tag, "_funct"}, 32'(bus.id_ex_funct), 32'(funct));
    check({tag, "_rd"},    32'(bus.id_ex_rd),    32'(rd));
  endtask

  task automatic drive(input logic [31:0] instr);
    @(negedge clk);
    bus.if_id_rdy   = 1'b1;
    bus.if_id_instr = instr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rstn            = 1'b0;
    bus.if_id_rdy   = 1'b0;
    bus.if_id_instr = '0;
    bus.id_ex_ack   = 1'b1;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;

    // Reset values
    #2;
    check("rst_rdy",     32'(bus.id_ex_rdy),   32'd0);
    check("rst_op1",     bus.id_ex_op1,        32'd0);
    check("rst_op2",     bus.id_ex_op2,        32'd0);
    check("rst_rd",      32'(bus.id_ex_rd),    32'd0);
    check("rst_illegal", 32'(bus.id_illegal),  32'd0);
    check("rst_funct",   32'(bus.id_ex_funct), 32'(EX_ADD));
    @(negedge clk);
    rstn = 1'b1;

    // Idle: nothing issued, ack asserted
    tick();
    tick();
    check("idle_rdy", 32'(bus.id_ex_rdy), 32'd0);
    check("idle_op2", bus.id_ex_op2,      32'd0);
    check("idle_ack", 32'(bus.if_id_ack), 32'd1);

    // ADDI x1,x0,5
    drive(I_ADDI_X1_5);
    check("addi_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    check_out("addi", 32'd0, 32'd5, EX_ADD, 5'd1);

    // ADD x2,x1,x1 stalls on busy x1
    drive(I_ADD_X2_X1_X1);
    check("add_stall_ack", 32'(bus.if_id_ack), 32'd0);
    tick();
    check("add_stall_rdy", 32'(bus.id_ex_rdy), 32'd0);

    // Writeback of x1 releases the stall in the same cycle via bypass
    @(negedge clk);
    bus.wb_we   = 1'b1;
    bus.wb_rd   = 5'd1;
    bus.wb_data = 32'd5;
    #1;
    check("add_wb_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    bus.wb_we = 1'b0;
    check_out("add", 32'd5, 32'd5, EX_ADD, 5'd2);

    // LUI and a sign-extended immediate, back to back
    drive(I_LUI_X3);
    tick();
    check_out("lui", 32'd0, 32'hABCD_E000, EX_ADD, 5'd3);
    drive(I_XORI_X8_M1);
    tick();
    check_out("xori", 32'd0, 32'hFFFF_FFFF, EX_XOR, 5'd8);

    // OP with unsupported funct7
    drive(I_MUL_X9);
    tick();
    check("mul_illegal", 32'(bus.id_illegal), 32'd1);
    check("mul_rdy",     32'(bus.id_ex_rdy),  32'd0);

    // SRAI with bad imm[11:5]
    drive(I_SRAI_BAD);
    check("srai_bad_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    check("srai_bad_illegal", 32'(bus.id_illegal), 32'd1);
    check("srai_bad_rdy",     32'(bus.id_ex_rdy),  32'd0);

    // x4 must not have been marked busy by the illegal instruction
    drive(I_ADD_X6_X4_X0);
    check("x4_free_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    check("add6_illegal", 32'(bus.id_illegal), 32'd0);
    check_out("add6", 32'd0, 32'd0, EX_ADD, 5'd6);

    // SRAI x4,x1,3
    drive(I_SRAI_X4_X1_3);
    tick();
    check_out("srai", 32'd5, 32'd3, EX_SRA, 5'd4);

    // Back-pressure with a pending instruction; write x0 meanwhile
    @(negedge clk);
    bus.id_ex_ack   = 1'b0;
    bus.if_id_rdy   = 1'b1;
    bus.if_id_instr = I_ADD_X5_X0_X0;
    bus.wb_we       = 1'b1;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'hFFFF_FFFF;
    #1;
    check("bp_ack", 32'(bus.if_id_ack), 32'd0);
    tick();
    check_out("bp_hold1", 32'd5, 32'd3, EX_SRA, 5'd4);
    tick();
    check_out("bp_hold2", 32'd5, 32'd3, EX_SRA, 5'd4);

    // Release: pending ADD x5,x0,x0 issues next edge, x0 still reads zero
    @(negedge clk);
    bus.id_ex_ack = 1'b1;
    #1;
    check("bp_release_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    bus.wb_we = 1'b0;
    check_out("add5", 32'd0, 32'd0, EX_ADD, 5'd5);

    // Reset in the middle of a stall on busy x5
    drive(I_ADD_X7_X5_X5);
    check("add7_stall_ack", 32'(bus.if_id_ack), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_rdy", 32'(bus.id_ex_rdy), 32'd0);
    check("midrst_rd",  32'(bus.id_ex_rd),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("postrst_ack", 32'(bus.if_id_ack), 32'd1);
    tick();
    check_out("add7", 32'd0, 32'd0, EX_ADD, 5'd7);

    // Drain
    @(negedge clk);
    bus.if_id_rdy = 1'b0;
    tick();
    check("drain_rdy", 32'(bus.id_ex_rdy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
